dm_access_ctrl: RTL and testbench

- Sequences the word-only 1024x32 data memory for two requesters: the pipeline MEM stage (CPU) and a word-wide debug/loader port.
- Provides byte and halfword loads/stores on top of a memory that only writes whole words. Sub-word stores use a two-cycle read-modify-write (RMW), and the MEM stage is stalled during it.
- Arbitrates the single memory port: CPU has priority, with a starvation guard for the debug port.
- Sits between the MEM stage/debug logic and the data memory.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_lane_unit.sv | 57 +++++
 rtl/dm_access_ctrl.sv | 132 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access controller: access sizes and sequencer states.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RMW_WR  = 2'd1,
        DBG_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: little-endian load select/extension and sub-word store merge.
// Size 2'b11 falls through to the word paths.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[7:0];
        case (lane)
            2'd0:    byte_sel = rword[7:0];
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase
        half_sel = lane[1] ? rword[31:16] : rword[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{sext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sext & half_sel[15]}}, half_sel};
            default: load_data = rword;
        endcase
    end

    // Merge keeps the untouched lanes of the current memory word.
    always_comb begin
        merge_data = rword;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Arbitrates the word-only data memory between the MEM stage and a debug port; loads and word
// stores take zero cycles, sub-word stores stall one cycle for read-modify-write, debug acks next cycle.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sext,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_misalign,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [9:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_wr,
    input  logic [31:0] dm_dout
);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      merge_q;
    logic [9:0]       addr_q;

    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        is_sub;
    logic        force_dbg;
    logic        dbg_grant;
    logic        cpu_go;
    logic        rmw_start;
    logic        wr_int;
    logic        stall_int;

    dm_lane_unit u_lane (
        .size       (cpu_size),
        .sext       (cpu_sext),
        .lane       (cpu_addr[1:0]),
        .rword      (dm_dout),
        .wdata      (cpu_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign is_sub       = (cpu_size == SZ_BYTE) || (cpu_size == SZ_HALF);
    assign cpu_misalign = cpu_req &&
                          (((cpu_size == SZ_HALF) && cpu_addr[0]) ||
                           (!is_sub && (cpu_addr[1:0] != 2'b00)));

    // Debug is never granted in RMW_WR or on its own ack cycle.
    assign force_dbg = dbg_req && (starve_cnt == CNT_W'(STARVE_MAX));
    assign dbg_grant = (state == IDLE) && dbg_req && (!cpu_req || force_dbg);
    assign cpu_go    = (state != RMW_WR) && cpu_req && !cpu_misalign && !dbg_grant;
    assign rmw_start = cpu_go && cpu_we && is_sub;

    always_comb begin
        dm_addr   = cpu_addr[11:2];
        dm_din    = cpu_wdata;
        wr_int    = 1'b0;
        stall_int = 1'b0;
        if (state == RMW_WR) begin
            dm_addr = addr_q;
            dm_din  = merge_q;
            wr_int  = 1'b1;
        end else if (dbg_grant) begin
            dm_addr   = dbg_addr;
            dm_din    = dbg_wdata;
            wr_int    = dbg_we;
            stall_int = cpu_req;
        end else if (cpu_go && cpu_we) begin
            if (is_sub)
                stall_int = 1'b1;
            else
                wr_int = 1'b1;
        end
    end

    // Gating with rst_n drops an in-flight RMW write the moment reset asserts.
    assign dm_wr     = wr_int & rst_n;
    assign cpu_stall = stall_int & rst_n;
    assign cpu_rdata = load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
            merge_q    <= '0;
            addr_q     <= '0;
            starve_cnt <= '0;
        end else begin
            dbg_ack <= dbg_grant;
            if (dbg_grant)
                dbg_rdata <= dm_dout;

            if (!dbg_req || dbg_grant)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            if (rmw_start) begin
                merge_q <= merge_data;
                addr_q  <= cpu_addr[11:2];
            end

            case (state)
                RMW_WR:  state <= IDLE;
                default: begin
                    if (dbg_grant)
                        state <= DBG_ACK;
                    else if (rmw_start)
                        state <= RMW_WR;
                    else
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a behavioural 1024x32 memory attached.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_sext;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_misalign;
    logic        dbg_req;
    logic        dbg_we;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_wr;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:1023];

    int total;
    int bad;

    dm_access_ctrl #(.STARVE_MAX(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_size     (cpu_size),
        .cpu_sext     (cpu_sext),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_misalign (cpu_misalign),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_rdata    (dbg_rdata),
        .dbg_ack      (dbg_ack),
        .dm_addr      (dm_addr),
        .dm_din       (dm_din),
        .dm_wr        (dm_wr),
        .dm_dout      (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_din;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [1:0] size,
                           input logic sext, input logic [11:0] addr, input logic [31:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_size  = size;
        cpu_sext  = sext;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic test_reset();
        set_cpu(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'h0BAD_0BAD);
        @(negedge clk);
        total++; if (dm_wr !== 1'b0) begin bad++; $display("FAIL reset_dm_wr got=%b want=0", dm_wr); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", cpu_stall); end
        total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_dbg_ack got=%b want=0", dbg_ack); end
        total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_dbg_rdata got=%h want=0", dbg_rdata); end
        step();
        set_cpu(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word();
        set_cpu(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
        @(negedge clk);
        total++; if (dm_wr !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL sw_ctrl got wr=%b stall=%b want wr=1 stall=0", dm_wr, cpu_stall); end
        total++; if (dm_din !== 32'hDEAD_BEEF || dm_addr !== 10'd4) begin bad++; $display("FAIL sw_bus got din=%h addr=%0d want din=deadbeef addr=4", dm_din, dm_addr); end
        step();
        set_cpu(1'b1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", cpu_rdata); end
        total++; if (dm_wr !== 1'b0 || cpu_stall !== 1'b0) begin bad++; $display("FAIL lw_ctrl got wr=%b stall=%b want 0 0", dm_wr, cpu_stall); end
        step();
    endtask

    task automatic sub_store(input string name, input logic [1:0] size, input logic [11:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_din);
        set_cpu(1'b1, 1'b1, 2'b10, 1'b0, {addr[11:2], 2'b00}, 32'h1122_3344);
        step();
        set_cpu(1'b1, 1'b1, size, 1'b0, addr, wdata);
        @(negedge clk);
        total++; if (cpu_stall !== 1'b1 || dm_wr !== 1'b0) begin bad++; $display("FAIL %s_rd got stall=%b wr=%b want 1 0", name, cpu_stall, dm_wr); end
        step();
        @(negedge clk);
        total++; if (dm_wr !== 1'b1 || cpu_stall !== 1'b0 || dm_din !== exp_din || dm_addr !== addr[11:2])
            begin bad++; $display("FAIL %s_wr got wr=%b stall=%b din=%h addr=%0d want 1 0 %h %0d", name, dm_wr, cpu_stall, dm_din, dm_addr, exp_din, addr[11:2]); end
        step();
    endtask

    task automatic load_chk(input string name, input logic [1:0] size, input logic sext,
                            input logic [11:0] addr, input logic [31:0] exp);
        set_cpu(1'b1, 1'b0, size, sext, addr, 32'h0);
        @(negedge clk);
        total++; if (cpu_rdata !== exp || cpu_stall !== 1'b0) begin bad++; $display("FAIL %s got=%h stall=%b want=%h stall=0", name, cpu_rdata, cpu_stall, exp); end
        step();
    endtask

    task automatic test_subword();
        sub_store("sb5a", 2'b00, 12'h013, 32'h0000_005A, 32'h5A22_3344);
        load_chk("lb_5a", 2'b00, 1'b1, 12'h013, 32'h0000_005A);
        sub_store("sb9a", 2'b00, 12'h013, 32'h0000_009A, 32'h9A22_3344);
        load_chk("lb_9a", 2'b00, 1'b1, 12'h013, 32'hFFFF_FF9A);
        load_chk("lbu_9a", 2'b00, 1'b0, 12'h013, 32'h0000_009A);
        sub_store("sh", 2'b01, 12'h012, 32'h0000_BEEF, 32'hBEEF_3344);
        load_chk("lhu", 2'b01, 1'b0, 12'h012, 32'h0000_BEEF);
        load_chk("lh", 2'b01, 1'b1, 12'h012, 32'hFFFF_BEEF);
        load_chk("lb_lane0", 2'b00, 1'b1, 12'h010, 32'h0000_0044);
    endtask

    task automatic test_misalign();
        set_cpu(1'b1, 1'b0, 2'b10, 1'b0, 12'h002, 32'h0);
        @(negedge clk);
        total++; if (cpu_misalign !== 1'b1 || dm_wr !== 1'b0 || cpu_stall !== 1'b0)
            begin bad++; $display("FAIL mis_lw got mis=%b wr=%b stall=%b want 1 0 0", cpu_misalign, dm_wr, cpu_stall); end
        step();
        set_cpu(1'b1, 1'b1, 2'b01, 1'b0, 12'h011, 32'h0000_1234);
        @(negedge clk);
        total++; if (cpu_misalign !== 1'b1 || dm_wr !== 1'b0 || cpu_stall !== 1'b0)
            begin bad++; $display("FAIL mis_sh got mis=%b wr=%b stall=%b want 1 0 0", cpu_misalign, dm_wr, cpu_stall); end
        step();
        @(negedge clk);
        total++; if (mem[4] !== 32'hBEEF_3344 || dm_wr !== 1'b0) begin bad++; $display("FAIL mis_mem got=%h wr=%b want=beef3344 wr=0", mem[4], dm_wr); end
        set_cpu(1'b0, 1'b0, 2'b10, 1'b0, 12'h002, 32'h0);
        #1;
        total++; if (cpu_misalign !== 1'b0) begin bad++; $display("FAIL mis_noreq got=%b want=0", cpu_misalign); end
        step();
    endtask

    task automatic test_starve();
        int grant_cyc;
        grant_cyc = -1;
        set_cpu(1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd5; dbg_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 20 && grant_cyc < 0; i++) begin
            @(negedge clk);
            if (dm_wr === 1'b1 && dm_addr === 10'd5) begin
                grant_cyc = i;
                total++; if (cpu_stall !== 1'b1 || dm_din !== 32'hCAFE_F00D)
                    begin bad++; $display("FAIL starve_grant got stall=%b din=%h want 1 cafef00d", cpu_stall, dm_din); end
            end
            step();
        end
        total++; if (grant_cyc != 8) begin bad++; $display("FAIL starve_cycles got=%0d want=8", grant_cyc); end
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1 || cpu_stall !== 1'b0 || dm_wr !== 1'b0)
            begin bad++; $display("FAIL starve_ack got ack=%b stall=%b wr=%b want 1 0 0", dbg_ack, cpu_stall, dm_wr); end
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        total++; if (dbg_ack !== 1'b0 || mem[5] !== 32'hCAFE_F00D) begin bad++; $display("FAIL starve_mem got ack=%b mem=%h want 0 cafef00d", dbg_ack, mem[5]); end
        step();
    endtask

    task automatic test_dbg_read();
        set_cpu(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd4; dbg_wdata = 32'h0;
        @(negedge clk);
        total++; if (dm_addr !== 10'd4 || dm_wr !== 1'b0 || dbg_ack !== 1'b0) begin bad++; $display("FAIL dbgrd_grant got addr=%0d wr=%b ack=%b want 4 0 0", dm_addr, dm_wr, dbg_ack); end
        step();
        @(negedge clk);
        total++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hBEEF_3344) begin bad++; $display("FAIL dbgrd_data got ack=%b data=%h want 1 beef3344", dbg_ack, dbg_rdata); end
        step();
        dbg_req = 1'b0;
        step();
    endtask

    task automatic test_reset_in_rmw();
        set_cpu(1'b1, 1'b1, 2'b10, 1'b0, 12'h020, 32'h1122_3344);
        step();
        set_cpu(1'b1, 1'b1, 2'b00, 1'b0, 12'h020, 32'h0000_0077);
        @(negedge clk);
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rstrmw_stall got=%b want=1", cpu_stall); end
        step();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (dm_wr !== 1'b0 || cpu_stall !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 32'h0)
            begin bad++; $display("FAIL rstrmw_out got wr=%b stall=%b ack=%b rdata=%h want 0 0 0 0", dm_wr, cpu_stall, dbg_ack, dbg_rdata); end
        step();
        total++; if (mem[8] !== 32'h1122_3344) begin bad++; $display("FAIL rstrmw_mem got=%h want=11223344", mem[8]); end
        set_cpu(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 10'd0; dbg_wdata = 32'h0;
        set_cpu(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        #1;
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_starve();
        test_dbg_read();
        test_reset_in_rmw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
